// File: rtl/grid_cond_sync_if.sv
// Handshake/status bundle between the PEs of one grid and the grid condition barrier.
interface grid_cond_sync_if #(
  parameter int N_PE = 16
);
  logic [N_PE-1:0] active_mask;
  logic [N_PE-1:0] pe_post_valid;
  logic [N_PE-1:0] pe_post_cond;
  logic [N_PE-1:0] pe_post_ready;
  logic [N_PE-1:0] pe_ack;
  logic [15:0]     cond_state;
  logic            cond_valid;
  logic [3:0]      epoch;
  logic            busy;

  modport master (
    output active_mask, pe_post_valid, pe_post_cond, pe_ack,
    input  pe_post_ready, cond_state, cond_valid, epoch, busy
  );

  modport slave (
    input  active_mask, pe_post_valid, pe_post_cond, pe_ack,
    output pe_post_ready, cond_state, cond_valid, epoch, busy
  );
endinterface

// File: rtl/grid_cond_sync.sv
// Grid branch-condition barrier: gathers one condition bit per masked PE, releases the vector once all have posted.
// Posts accepted combinationally, cond_valid one cycle after the final accept; optional collect timeout via GRID_SYNC_TIMEOUT_EN.
module grid_cond_sync #(
  parameter int N_PE      = 16,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  grid_cond_sync_if.slave      bus
`ifdef GRID_SYNC_TIMEOUT_EN
  ,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  output logic                 timeout_err
`endif
);

  typedef enum logic [1:0] {IDLE, COLLECT, RELEASE} state_t;

  state_t          state;
  logic [N_PE-1:0] mask_q;
  logic [N_PE-1:0] arrived;
  logic [N_PE-1:0] acked;
  logic [N_PE-1:0] cond_q;
  logic            cond_valid_q;
  logic            busy_q;
  logic [3:0]      epoch_q;

  logic [N_PE-1:0] mask_eff;
  logic [N_PE-1:0] ready;
  logic [N_PE-1:0] accepted;
  logic [N_PE-1:0] arrived_nxt;
  logic [N_PE-1:0] acked_nxt;
  logic [N_PE-1:0] cond_nxt;
  logic            to_hit;

  // The live mask only matters in IDLE; once an epoch starts the sampled copy rules.
  assign mask_eff    = (state == IDLE) ? bus.active_mask : mask_q;
  assign ready       = (state == RELEASE) ? '0 : (~arrived & mask_eff);
  assign accepted    = bus.pe_post_valid & ready;
  assign arrived_nxt = arrived | accepted;
  assign acked_nxt   = acked | (bus.pe_ack & mask_q);
  assign cond_nxt    = (cond_q & ~accepted) | (bus.pe_post_cond & accepted);

  assign bus.pe_post_ready = ready;
  assign bus.cond_state    = 16'(cond_q);
  assign bus.cond_valid    = cond_valid_q;
  assign bus.busy          = busy_q;
  assign bus.epoch         = epoch_q;

`ifdef GRID_SYNC_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt;
  logic [TIMEOUT_W-1:0] to_cnt_inc;
  logic                 timeout_err_q;

  assign to_cnt_inc  = to_cnt + TIMEOUT_W'(1);
  assign to_hit      = (timeout_cycles != '0) && (to_cnt_inc >= timeout_cycles);
  assign timeout_err = timeout_err_q;
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mask_q       <= '0;
      arrived      <= '0;
      acked        <= '0;
      cond_q       <= '0;
      cond_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      epoch_q      <= 4'd0;
`ifdef GRID_SYNC_TIMEOUT_EN
      to_cnt        <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accepted != '0) begin
            mask_q  <= bus.active_mask;
            arrived <= arrived_nxt;
            cond_q  <= cond_nxt;
            busy_q  <= 1'b1;
`ifdef GRID_SYNC_TIMEOUT_EN
            to_cnt  <= '0;
`endif
            if (arrived_nxt == bus.active_mask) begin
              state        <= RELEASE;
              cond_valid_q <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          arrived <= arrived_nxt;
          cond_q  <= cond_nxt;
`ifdef GRID_SYNC_TIMEOUT_EN
          to_cnt  <= to_cnt_inc;
`endif
          if (arrived_nxt == mask_q) begin
            state        <= RELEASE;
            cond_valid_q <= 1'b1;
          end else if (to_hit) begin
            // Missing PEs are dropped from the ack set; their cond bits stay 0.
            state        <= RELEASE;
            cond_valid_q <= 1'b1;
            mask_q       <= arrived_nxt;
`ifdef GRID_SYNC_TIMEOUT_EN
            timeout_err_q <= 1'b1;
`endif
          end
        end
        RELEASE: begin
          acked <= acked_nxt;
          if (acked_nxt == mask_q) begin
            state        <= IDLE;
            arrived      <= '0;
            acked        <= '0;
            cond_q       <= '0;
            cond_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            epoch_q      <= epoch_q + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_cond_sync.sv
// Scoreboard bench for grid_cond_sync; expected cond vectors queued at post time, checked on release.
`timescale 1ns/1ps
module tb_grid_cond_sync;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  grid_cond_sync_if #(.N_PE(16)) bus ();

`ifdef GRID_SYNC_TIMEOUT_EN
  logic [15:0] timeout_cycles;
  logic        timeout_err;
`endif

  grid_cond_sync #(.N_PE(16), .TIMEOUT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef GRID_SYNC_TIMEOUT_EN
    ,
    .timeout_cycles (timeout_cycles),
    .timeout_err    (timeout_err)
`endif
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  exp_epoch;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pe_post_valid = '0;
    bus.pe_post_cond  = '0;
    bus.pe_ack        = '0;
  endtask

  // Waits up to budget cycles for cond_valid, then checks against the scoreboard head.
  task automatic wait_release(input string name, input int budget, output int cycles);
    logic [15:0] exp;
    cycles = 0;
    while (bus.cond_valid !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s_sb: no expected entry queued", name);
    end else begin
      exp = exp_q.pop_front();
      if (bus.cond_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s_release: cond_valid=%b after %0d cycles, required 1", name, bus.cond_valid, cycles);
      end else if (bus.cond_state !== exp) begin
        tests_failed++;
        $display("FAIL %s_cond: cond_state=%h required %h", name, bus.cond_state, exp);
      end
    end
  endtask

  task automatic ack_all(input string name, input logic [15:0] ack);
    bus.pe_ack = ack;
    tick();
    bus.pe_ack = '0;
    exp_epoch++;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.cond_valid !== 1'b0 || bus.epoch !== exp_epoch) begin
      tests_failed++;
      $display("FAIL %s_ack: busy=%b cond_valid=%b epoch=%0d required 0/0/%0d",
               name, bus.busy, bus.cond_valid, bus.epoch, exp_epoch);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.active_mask = '0;
    idle_inputs();
`ifdef GRID_SYNC_TIMEOUT_EN
    timeout_cycles = '0;
`endif
    exp_epoch = 4'd0;
    tick();
    tick();
    tests_run++;
    if (bus.cond_state !== 16'h0 || bus.cond_valid !== 1'b0 || bus.epoch !== 4'd0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: cond=%h valid=%b epoch=%0d busy=%b required 0/0/0/0",
               bus.cond_state, bus.cond_valid, bus.epoch, bus.busy);
    end
`ifdef GRID_SYNC_TIMEOUT_EN
    tests_run++;
    if (timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_timeout_err: got %b required 0", timeout_err);
    end
`endif
    rst = 1'b0;
    bus.pe_post_valid = 16'hFFFF;
    #1;
    tests_run++;
    if (bus.pe_post_ready !== 16'h0) begin
      tests_failed++;
      $display("FAIL zero_mask_ready: got %h required 0000", bus.pe_post_ready);
    end
    tick();
    idle_inputs();
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_mask_busy: got %b required 0", bus.busy);
    end
  endtask

  task automatic test_all_post();
    int cyc;
    bus.active_mask   = 16'hFFFF;
    bus.pe_post_valid = 16'hFFFF;
    bus.pe_post_cond  = 16'h0000;
    exp_q.push_back(16'h0000);
    #1;
    tests_run++;
    if (bus.pe_post_ready !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL all_post_ready: got %h required ffff", bus.pe_post_ready);
    end
    tick();
    idle_inputs();
    wait_release("all_post", 0, cyc);
    ack_all("all_post", 16'hFFFF);
  endtask

  task automatic test_staggered();
    int cyc;
    bus.active_mask = 16'h000F;
    exp_q.push_back(16'h0004);
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      if (c == 0) bus.pe_post_valid[0] = 1'b1;
      if (c == 2) bus.pe_post_valid[1] = 1'b1;
      if (c == 5) begin bus.pe_post_valid[2] = 1'b1; bus.pe_post_cond[2] = 1'b1; end
      if (c == 7) bus.pe_post_valid[3] = 1'b1;
      #1;
      tests_run++;
      if (bus.cond_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL stagger_early_valid: cycle %0d cond_valid=%b required 0", c, bus.cond_valid);
      end
      tick();
    end
    idle_inputs();
    wait_release("stagger", 0, cyc);
  endtask

  task automatic test_release_stall();
    bus.pe_post_valid = 16'h0021;
    bus.pe_post_cond  = 16'hFFFF;
    #1;
    tests_run++;
    if (bus.pe_post_ready !== 16'h0) begin
      tests_failed++;
      $display("FAIL stall_ready: got %h required 0000", bus.pe_post_ready);
    end
    tick();
    idle_inputs();
    tests_run++;
    if (bus.cond_state !== 16'h0004 || bus.cond_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_frozen: cond=%h valid=%b required 0004/1", bus.cond_state, bus.cond_valid);
    end
    ack_all("stall", 16'h000F);
  endtask

  task automatic test_partial_ack();
    int cyc;
    bus.active_mask   = 16'h0003;
    bus.pe_post_valid = 16'h0003;
    bus.pe_post_cond  = 16'h0002;
    exp_q.push_back(16'h0002);
    tick();
    idle_inputs();
    wait_release("partial", 0, cyc);
    bus.pe_ack = 16'h0002;
    tick();
    bus.pe_ack = '0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bus.cond_valid !== 1'b1 || bus.busy !== 1'b1 || bus.cond_state !== 16'h0002) begin
        tests_failed++;
        $display("FAIL partial_hold: step %0d valid=%b busy=%b cond=%h required 1/1/0002",
                 i, bus.cond_valid, bus.busy, bus.cond_state);
      end
      if (i < 2) tick();
    end
    ack_all("partial", 16'h0001);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bus.active_mask   = 16'h000F;
    bus.pe_post_valid = 16'h0005;
    bus.pe_post_cond  = 16'h0005;
    tick();
    idle_inputs();
    tests_run++;
    if (bus.busy !== 1'b1 || bus.cond_state !== 16'h0005 || bus.cond_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL collect_state: busy=%b cond=%h valid=%b required 1/0005/0",
               bus.busy, bus.cond_state, bus.cond_valid);
    end
    // Re-post from an arrived PE and a post from a PE outside the sampled mask.
    bus.active_mask   = 16'hFFFF;
    bus.pe_post_valid = 16'h0021;
    #1;
    tests_run++;
    if (bus.pe_post_ready !== 16'h000A) begin
      tests_failed++;
      $display("FAIL dup_ready: got %h required 000a", bus.pe_post_ready);
    end
    tick();
    idle_inputs();
    tests_run++;
    if (bus.cond_state !== 16'h0005) begin
      tests_failed++;
      $display("FAIL dup_nochange: cond=%h required 0005", bus.cond_state);
    end
    #2;
    rst = 1'b1;
    #1;
    exp_epoch = 4'd0;
    tests_run++;
    if (bus.cond_state !== 16'h0 || bus.busy !== 1'b0 || bus.epoch !== 4'd0 || bus.cond_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: cond=%h busy=%b epoch=%0d valid=%b required 0/0/0/0",
               bus.cond_state, bus.busy, bus.epoch, bus.cond_valid);
    end
    tick();
    rst = 1'b0;
    bus.active_mask   = 16'h0003;
    bus.pe_post_valid = 16'h0003;
    bus.pe_post_cond  = 16'h0001;
    exp_q.push_back(16'h0001);
    tick();
    idle_inputs();
    wait_release("post_reset", 0, cyc);
    ack_all("post_reset", 16'h0003);
  endtask

  task automatic test_back_to_back();
    int cyc;
    bus.active_mask   = 16'h0001;
    bus.pe_post_valid = 16'h0001;
    bus.pe_post_cond  = 16'h0001;
    exp_q.push_back(16'h0001);
    tick();
    idle_inputs();
    wait_release("b2b_first", 0, cyc);
    bus.pe_ack        = 16'h0001;
    bus.pe_post_valid = 16'h0001;
    bus.pe_post_cond  = 16'h0000;
    #1;
    tests_run++;
    if (bus.pe_post_ready !== 16'h0) begin
      tests_failed++;
      $display("FAIL b2b_same_edge_ready: got %h required 0000", bus.pe_post_ready);
    end
    tick();
    bus.pe_ack = '0;
    exp_epoch++;
    tests_run++;
    if (bus.cond_valid !== 1'b0 || bus.epoch !== exp_epoch || bus.pe_post_ready !== 16'h0001) begin
      tests_failed++;
      $display("FAIL b2b_idle: valid=%b epoch=%0d ready=%h required 0/%0d/0001",
               bus.cond_valid, bus.epoch, bus.pe_post_ready, exp_epoch);
    end
    exp_q.push_back(16'h0000);
    tick();
    idle_inputs();
    wait_release("b2b_second", 0, cyc);
    ack_all("b2b", 16'h0001);
  endtask

`ifdef GRID_SYNC_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    timeout_cycles    = 16'd10;
    bus.active_mask   = 16'h0003;
    bus.pe_post_valid = 16'h0001;
    bus.pe_post_cond  = 16'h0001;
    exp_q.push_back(16'h0001);
    tick();
    idle_inputs();
    wait_release("timeout", 20, cyc);
    tests_run++;
    if (cyc != 10 || timeout_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_fire: cycles=%0d err=%b required 10/1", cyc, timeout_err);
    end
    ack_all("timeout", 16'h0001);
    timeout_cycles = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_all_post();
    test_staggered();
    test_release_stall();
    test_partial_ack();
    test_reset_mid();
    test_back_to_back();
`ifdef GRID_SYNC_TIMEOUT_EN
    test_timeout();
`endif
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
